// File: rtl/spart_pkg.sv
// Shared constants for the SPART host driver: bus addresses, FSM state
// encoding and the baud divisor helper evaluated at elaboration.
package spart_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DIV_LO = 2'b10;
    localparam logic [1:0] ADDR_DIV_HI = 2'b11;

    typedef enum logic [2:0] {
        ST_CFG_LO   = 3'd0,
        ST_CFG_HI   = 3'd1,
        ST_IDLE     = 3'd2,
        ST_RX_READ  = 3'd3,
        ST_TX_WRITE = 3'd4
    } spart_state_e;

    function automatic logic [15:0] spart_divisor(input int unsigned clk_hz,
                                                  input int unsigned baud);
        int unsigned q;
        q = clk_hz / (16 * baud) - 1;
        return q[15:0];
    endfunction

endpackage

// File: rtl/spart_host_driver_if.sv
// SPART control/handshake signals. The 8-bit tristate data bus stays a
// plain inout port on the driver so it resolves cleanly at module level.
interface spart_host_driver_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;

    modport master (output iocs, iorw, ioaddr, input rda, tbr);
    modport slave  (input iocs, iorw, ioaddr, output rda, tbr);
endinterface

// File: rtl/spart_drv_fifo.sv
// Byte FIFO holding received bytes awaiting echo. Push while full and pop
// while empty are ignored; pointers wrap modulo FIFO_DEPTH.
module spart_drv_fifo #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [7:0]                    push_data,
    input  logic                          pop,
    output logic [7:0]                    pop_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        full     = (count_q == (PW+1)'(FIFO_DEPTH));
        empty    = (count_q == '0);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) count_d = count_q + (PW+1)'(1);
        if (do_pop && !do_push) count_d = count_q - (PW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/spart_host_driver.sv
// SPART host driver: programs the baud divisor, then echoes received bytes
// back out through a FIFO. Define SPART_DRV_UPCASE_EN to upper-case a-z.
//
// state       | meaning
// CFG_LO      | write divisor low byte (ioaddr 10)
// CFG_HI      | write divisor high byte (ioaddr 11)
// IDLE        | no access; pick reconfig > rx > tx
// RX_READ     | read data register, push byte into FIFO
// TX_WRITE    | write FIFO head to data register, pop
module spart_host_driver
    import spart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50000000,
    parameter int          FIFO_DEPTH  = 8,
    parameter int unsigned BAUD0       = 4800,
    parameter int unsigned BAUD1       = 9600,
    parameter int unsigned BAUD2       = 19200,
    parameter int unsigned BAUD3       = 38400
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    br_cfg,
    spart_host_driver_if.master           bus,
    inout  wire  [7:0]                    databus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam logic [15:0] DIV0 = spart_divisor(CLK_FREQ_HZ, BAUD0);
    localparam logic [15:0] DIV1 = spart_divisor(CLK_FREQ_HZ, BAUD1);
    localparam logic [15:0] DIV2 = spart_divisor(CLK_FREQ_HZ, BAUD2);
    localparam logic [15:0] DIV3 = spart_divisor(CLK_FREQ_HZ, BAUD3);

    function automatic logic [15:0] div_for(input logic [1:0] cfg);
        case (cfg)
            2'b00:   return DIV0;
            2'b01:   return DIV1;
            2'b10:   return DIV2;
            default: return DIV3;
        endcase
    endfunction

    spart_state_e state_q, state_d;
    logic [1:0]   br_cfg_q, br_cfg_d;
    logic [1:0]   prog_cfg_q, prog_cfg_d;
    logic         overflow_q, overflow_d;

    logic         cs, rw;
    logic [1:0]   addr;
    logic [7:0]   drv_data;
    logic [1:0]   cfg_sel;
    logic [15:0]  div_sel;
    logic         push, pop, full, empty;
    logic [7:0]   push_data, head;

    // CFG_LO uses the freshly registered select; CFG_HI reuses what CFG_LO latched
    assign cfg_sel = (state_q == ST_CFG_LO) ? br_cfg_q : prog_cfg_q;
    assign div_sel = div_for(cfg_sel);

`ifdef SPART_DRV_UPCASE_EN
    assign push_data = (databus >= 8'h61 && databus <= 8'h7A) ? databus - 8'h20 : databus;
`else
    assign push_data = databus;
`endif

    always_comb begin
        br_cfg_d   = br_cfg;
        state_d    = state_q;
        prog_cfg_d = prog_cfg_q;
        overflow_d = overflow_q;
        cs         = 1'b0;
        rw         = 1'b1;
        addr       = ADDR_DATA;
        drv_data   = 8'h00;
        push       = 1'b0;
        pop        = 1'b0;
        case (state_q)
            ST_CFG_LO: begin
                cs         = 1'b1;
                rw         = 1'b0;
                addr       = ADDR_DIV_LO;
                drv_data   = div_sel[7:0];
                prog_cfg_d = br_cfg_q;
                state_d    = ST_CFG_HI;
            end
            ST_CFG_HI: begin
                cs       = 1'b1;
                rw       = 1'b0;
                addr     = ADDR_DIV_HI;
                drv_data = div_sel[15:8];
                state_d  = ST_IDLE;
            end
            ST_IDLE: begin
                if (br_cfg_q != prog_cfg_q)     state_d = ST_CFG_LO;
                else if (bus.rda)               state_d = ST_RX_READ;
                else if (bus.tbr && !empty)     state_d = ST_TX_WRITE;
            end
            ST_RX_READ: begin
                cs   = 1'b1;
                push = 1'b1;
                if (full) overflow_d = 1'b1;
                state_d = ST_IDLE;
            end
            ST_TX_WRITE: begin
                cs       = 1'b1;
                rw       = 1'b0;
                drv_data = head;
                pop      = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_CFG_LO;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_CFG_LO;
            prog_cfg_q <= 2'b00;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prog_cfg_q <= prog_cfg_d;
            overflow_q <= overflow_d;
        end
    end

    // Keeps sampling during reset so the first CFG_LO sees the live select
    always_ff @(posedge clk) br_cfg_q <= br_cfg_d;

    spart_drv_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    // Reset gates the bus directly so an in-flight access drops immediately
    assign bus.iocs   = cs && rst;
    assign bus.iorw   = rw || !rst;
    assign bus.ioaddr = rst ? addr : ADDR_DATA;
    assign databus    = (cs && !rw && rst) ? drv_data : 8'hzz;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_spart_host_driver.sv
// Directed bench for spart_host_driver: divisor table, echo ordering,
// overflow, rx/tx priority and reset abort.
module tb_spart_host_driver;
    import spart_pkg::*;

    localparam int DEPTH = 8;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [1:0]              br_cfg = 2'b01;
    wire  [7:0]              databus;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic                    overflow;
    logic                    probe_en = 1'b0;
    logic [7:0]              rx_val = 8'h00;
    logic                    tb_en;
    logic [7:0]              tb_val;
    int                      checks = 0;
    int                      errors = 0;

`ifdef SPART_DRV_UPCASE_EN
    localparam logic [7:0] EXP_SECOND = 8'h49;
`else
    localparam logic [7:0] EXP_SECOND = 8'h69;
`endif

    typedef struct packed {
        logic [1:0] cfg;
        logic [7:0] lo;
        logic [7:0] hi;
    } cfg_vec_t;

    cfg_vec_t vecs [4];

    spart_host_driver_if bus_if ();

    spart_host_driver #(
        .CLK_FREQ_HZ (50000000),
        .FIFO_DEPTH  (DEPTH),
        .BAUD0       (4800),
        .BAUD1       (9600),
        .BAUD2       (19200),
        .BAUD3       (38400)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .br_cfg     (br_cfg),
        .bus        (bus_if),
        .databus    (databus),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Device model: answers reads with rx_val; probe drives a marker to show the DUT is off the bus
    always_comb begin
        tb_en  = probe_en || (bus_if.iocs && bus_if.iorw);
        tb_val = probe_en ? 8'h5A : rx_val;
    end
    assign databus = tb_en ? tb_val : 8'hzz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        check(name, 32'({bus_if.iocs, bus_if.iorw, bus_if.ioaddr}), 32'(4'b0100));
    endtask

    task automatic expect_acc(input string name, input int max_wait, input logic rw,
                              input logic [1:0] addr, input logic [7:0] data, input bit clr_rda);
        int n;
        n = 0;
        while (!bus_if.iocs && n < max_wait) begin
            step();
            n++;
        end
        if (!bus_if.iocs) begin
            checks++;
            errors++;
            $display("FAIL %s: no access within %0d cycles, expected rw=%0d addr=%0d data=0x%0h",
                     name, max_wait, rw, addr, data);
        end else begin
            check(name, 32'({bus_if.iorw, bus_if.ioaddr, databus}), 32'({rw, addr, data}));
        end
        if (clr_rda) bus_if.rda = 1'b0;
        step();
    endtask

    task automatic rx(input logic [7:0] b, input string name);
        rx_val     = b;
        bus_if.rda = 1'b1;
        expect_acc(name, 4, 1'b1, ADDR_DATA, b, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200us, expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        vecs[0] = '{cfg: 2'b11, lo: 8'h50, hi: 8'h00};
        vecs[1] = '{cfg: 2'b00, lo: 8'h8A, hi: 8'h02};
        vecs[2] = '{cfg: 2'b10, lo: 8'hA1, hi: 8'h00};
        vecs[3] = '{cfg: 2'b01, lo: 8'h44, hi: 8'h01};

        bus_if.rda = 1'b0;
        bus_if.tbr = 1'b0;
        repeat (3) step();

        probe_en = 1'b1;
        #1;
        check_idle("reset_bus");
        check("reset_databus_hiz", 32'(databus), 32'(8'h5A));
        check("reset_fifo_count", 32'(fifo_count), 32'(0));
        check("reset_overflow", 32'(overflow), 32'(0));
        probe_en = 1'b0;
        rst = 1'b1;
        #1;

        expect_acc("boot_cfg_lo", 0, 1'b0, ADDR_DIV_LO, 8'h44, 1'b0);
        expect_acc("boot_cfg_hi", 0, 1'b0, ADDR_DIV_HI, 8'h01, 1'b0);
        check_idle("boot_idle");
        probe_en = 1'b1;
        #1;
        check("idle_databus_hiz", 32'(databus), 32'(8'h5A));
        probe_en = 1'b0;
        #1;

        for (int i = 0; i < 4; i++) begin
            br_cfg = vecs[i].cfg;
            expect_acc("tbl_cfg_lo", 4, 1'b0, ADDR_DIV_LO, vecs[i].lo, 1'b0);
            expect_acc("tbl_cfg_hi", 0, 1'b0, ADDR_DIV_HI, vecs[i].hi, 1'b0);
            check_idle("tbl_idle");
        end

        // reconfig must win over a pending rx in the same idle cycle
        br_cfg = 2'b10;
        step();
        check_idle("prio_idle");
        rx_val     = 8'h21;
        bus_if.rda = 1'b1;
        expect_acc("prio_cfg_lo", 1, 1'b0, ADDR_DIV_LO, 8'hA1, 1'b0);
        expect_acc("prio_cfg_hi", 0, 1'b0, ADDR_DIV_HI, 8'h00, 1'b0);
        expect_acc("prio_rx", 2, 1'b1, ADDR_DATA, 8'h21, 1'b1);
        check("prio_count", 32'(fifo_count), 32'(1));
        bus_if.tbr = 1'b1;
        expect_acc("drain_tx", 3, 1'b0, ADDR_DATA, 8'h21, 1'b0);
        bus_if.tbr = 1'b0;
        check("drain_count", 32'(fifo_count), 32'(0));

        rx(8'h48, "echo_rx0");
        rx(8'h69, "echo_rx1");
        check("echo_count", 32'(fifo_count), 32'(2));
        bus_if.tbr = 1'b1;
        expect_acc("echo_tx0", 3, 1'b0, ADDR_DATA, 8'h48, 1'b0);
        check_idle("echo_gap");
        expect_acc("echo_tx1", 3, 1'b0, ADDR_DATA, EXP_SECOND, 1'b0);
        bus_if.tbr = 1'b0;
        check("echo_count_empty", 32'(fifo_count), 32'(0));

        rx(8'h41, "both_pre_rx");
        rx_val     = 8'h42;
        bus_if.rda = 1'b1;
        bus_if.tbr = 1'b1;
        expect_acc("both_rx_first", 2, 1'b1, ADDR_DATA, 8'h42, 1'b1);
        expect_acc("both_tx_next", 3, 1'b0, ADDR_DATA, 8'h41, 1'b0);
        expect_acc("both_tx_second", 3, 1'b0, ADDR_DATA, 8'h42, 1'b0);
        bus_if.tbr = 1'b0;
        check("both_count", 32'(fifo_count), 32'(0));

        for (int i = 0; i <= DEPTH; i++) begin
            rx(8'(8'h30 + i), "ovf_rx");
            if (i == DEPTH - 1) begin
                check("ovf_count_full", 32'(fifo_count), 32'(DEPTH));
                check("ovf_not_yet", 32'(overflow), 32'(0));
            end
        end
        check("ovf_count_after", 32'(fifo_count), 32'(DEPTH));
        check("ovf_set", 32'(overflow), 32'(1));
        bus_if.tbr = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            expect_acc("ovf_tx", 3, 1'b0, ADDR_DATA, 8'(8'h30 + i), 1'b0);
        end
        n = 0;
        repeat (10) begin
            if (bus_if.iocs) n++;
            step();
        end
        check("ovf_no_extra_tx", 32'(n), 32'(0));
        bus_if.tbr = 1'b0;
        check("ovf_sticky", 32'(overflow), 32'(1));
        check("ovf_drained", 32'(fifo_count), 32'(0));

        rx(8'h55, "rst_rx0");
        rx(8'h66, "rst_rx1");
        bus_if.tbr = 1'b1;
        n = 0;
        while (!bus_if.iocs && n < 4) begin
            step();
            n++;
        end
        check("rst_tx_seen", 32'({bus_if.iocs, bus_if.iorw, bus_if.ioaddr, databus}),
              32'({1'b1, 1'b0, ADDR_DATA, 8'h55}));
        rst      = 1'b0;
        probe_en = 1'b1;
        #1;
        check_idle("rst_abort_bus");
        check("rst_abort_databus", 32'(databus), 32'(8'h5A));
        check("rst_abort_count", 32'(fifo_count), 32'(0));
        check("rst_abort_overflow", 32'(overflow), 32'(0));
        bus_if.tbr = 1'b0;
        step();
        step();
        check_idle("rst_hold_bus");
        probe_en = 1'b0;
        rst      = 1'b1;
        #1;
        expect_acc("rst_cfg_lo", 0, 1'b0, ADDR_DIV_LO, 8'hA1, 1'b0);
        expect_acc("rst_cfg_hi", 0, 1'b0, ADDR_DIV_HI, 8'h00, 1'b0);
        check_idle("rst_final_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
